// File: rtl/mmio_timer_host_device.sv
// MMIO responder: 64-bit machine timer (mtime/mtimecmp with prescaler),
// registered timer interrupt, and a tohost/fromhost pair whose tohost
// write with bit 0 set latches a sticky halt for simulation termination.
module mmio_timer_host_device #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        in_read_enable,
   input  logic [31:0] in_read_address,
   input  logic        in_write_enable,
   input  logic [31:0] in_write_address,
   input  logic [31:0] in_write_data,
   output logic        out_read_hit,
   output logic        out_write_hit,
   output logic [31:0] out_read_data,
   output logic        out_read_exception_valid,
   output logic [3:0]  out_read_exception_code,
   output logic        out_write_exception_valid,
   output logic [3:0]  out_write_exception_code,
   output logic        out_timer_interrupt,
   output logic        out_halt,
   output logic [30:0] out_halt_code
);

   // Word indices of the mapped registers (offset[11:2]).
   localparam logic [9:0] IDX_MTIME_LO    = 10'd0;
   localparam logic [9:0] IDX_MTIME_HI    = 10'd1;
   localparam logic [9:0] IDX_MTIMECMP_LO = 10'd2;
   localparam logic [9:0] IDX_MTIMECMP_HI = 10'd3;
   localparam logic [9:0] IDX_TOHOST      = 10'd4;
   localparam logic [9:0] IDX_FROMHOST    = 10'd5;
   localparam logic [9:0] IDX_LAST        = IDX_FROMHOST;

   localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

   // Misalignment outranks an unmapped offset; 0 means no fault.
   function automatic logic [3:0] fault_code(input logic [11:0] off,
                                             input logic [3:0]  mis_code,
                                             input logic [3:0]  unmapped_code);
      if (off[1:0] != 2'b00)
         fault_code = mis_code;
      else if (off[11:2] > IDX_LAST)
         fault_code = unmapped_code;
      else
         fault_code = 4'd0;
   endfunction

   logic [63:0] mtime_reg,    mtime_next;
   logic [63:0] mtimecmp_reg, mtimecmp_next;
   logic [15:0] presc_reg,    presc_next;
   logic [31:0] tohost_reg,   tohost_next;
   logic [31:0] fromhost_reg, fromhost_next;
   logic        irq_reg,      irq_next;
   logic        halt_reg,     halt_next;
   logic [30:0] halt_code_reg, halt_code_next;

   logic        rd_active;
   logic [3:0]  rd_code;
   logic [9:0]  rd_idx;
   logic [31:0] rd_word;
   logic        wr_commit;
   logic [3:0]  wr_code;
   logic [9:0]  wr_idx;
   logic        tick;
   logic        wr_mtime;

   assign out_read_hit  = (in_read_address[31:12]  == BASE_ADDR[31:12]);
   assign out_write_hit = (in_write_address[31:12] == BASE_ADDR[31:12]);

   assign rd_code   = fault_code(in_read_address[11:0], 4'd4, 4'd5);
   assign rd_active = in_read_enable && out_read_hit;
   assign rd_idx    = in_read_address[11:2];

   assign wr_code   = fault_code(in_write_address[11:0], 4'd6, 4'd7);
   assign wr_commit = in_write_enable && out_write_hit && (wr_code == 4'd0);
   assign wr_idx    = in_write_address[11:2];

   assign out_read_exception_valid  = rd_active && (rd_code != 4'd0);
   assign out_read_exception_code   = out_read_exception_valid ? rd_code : 4'd0;
   assign out_write_exception_valid = in_write_enable && out_write_hit && (wr_code != 4'd0);
   assign out_write_exception_code  = out_write_exception_valid ? wr_code : 4'd0;

   // Combinational read mux over the pre-write register values.
   always_comb begin
      rd_word = 32'd0;
      case (rd_idx)
         IDX_MTIME_LO:    rd_word = mtime_reg[31:0];
         IDX_MTIME_HI:    rd_word = mtime_reg[63:32];
         IDX_MTIMECMP_LO: rd_word = mtimecmp_reg[31:0];
         IDX_MTIMECMP_HI: rd_word = mtimecmp_reg[63:32];
         IDX_TOHOST:      rd_word = tohost_reg;
         IDX_FROMHOST:    rd_word = fromhost_reg;
         default:         rd_word = 32'd0;
      endcase
   end

   assign out_read_data = (rd_active && (rd_code == 4'd0)) ? rd_word : 32'd0;

   // Next-state: software writes win over the timer tick; halt freezes the timer.
   always_comb begin
      mtime_next     = mtime_reg;
      mtimecmp_next  = mtimecmp_reg;
      presc_next     = presc_reg;
      tohost_next    = tohost_reg;
      fromhost_next  = fromhost_reg;
      halt_next      = halt_reg;
      halt_code_next = halt_code_reg;

      tick     = (presc_reg == PRESC_MAX) && !halt_reg;
      wr_mtime = wr_commit && ((wr_idx == IDX_MTIME_LO) || (wr_idx == IDX_MTIME_HI));

      if (wr_mtime)
         presc_next = 16'd0;
      else if (halt_reg)
         presc_next = presc_reg;
      else if (tick)
         presc_next = 16'd0;
      else
         presc_next = presc_reg + 16'd1;

      if (wr_commit && (wr_idx == IDX_MTIME_LO))
         mtime_next[31:0] = in_write_data;
      else if (wr_commit && (wr_idx == IDX_MTIME_HI))
         mtime_next[63:32] = in_write_data;
      else if (tick)
         mtime_next = mtime_reg + 64'd1;

      if (wr_commit && (wr_idx == IDX_MTIMECMP_LO))
         mtimecmp_next[31:0] = in_write_data;
      if (wr_commit && (wr_idx == IDX_MTIMECMP_HI))
         mtimecmp_next[63:32] = in_write_data;

      if (wr_commit && (wr_idx == IDX_TOHOST)) begin
         tohost_next = in_write_data;
         if (in_write_data[0] && !halt_reg) begin
            halt_next      = 1'b1;
            halt_code_next = in_write_data[31:1];
         end
      end

      if (wr_commit && (wr_idx == IDX_FROMHOST))
         fromhost_next = in_write_data;

      irq_next = (mtime_next >= mtimecmp_next);
   end

   // State registers with synchronous reset overriding writes and ticks.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mtime_reg     <= 64'd0;
         mtimecmp_reg  <= '1;
         presc_reg     <= 16'd0;
         tohost_reg    <= 32'd0;
         fromhost_reg  <= 32'd0;
         irq_reg       <= 1'b0;
         halt_reg      <= 1'b0;
         halt_code_reg <= 31'd0;
      end else begin
         mtime_reg     <= mtime_next;
         mtimecmp_reg  <= mtimecmp_next;
         presc_reg     <= presc_next;
         tohost_reg    <= tohost_next;
         fromhost_reg  <= fromhost_next;
         irq_reg       <= irq_next;
         halt_reg      <= halt_next;
         halt_code_reg <= halt_code_next;
      end
   end

   assign out_timer_interrupt = irq_reg;
   assign out_halt            = halt_reg;
   assign out_halt_code       = halt_code_reg;

endmodule

// File: tb/tb_mmio_timer_host_device.sv
// Bench for mmio_timer_host_device: two instances (TICK_DIV 1 and 3) share the
// bus inputs but have separate resets; a register-level model is compared on
// every negedge, plus directed literal expectations.
module tb_mmio_timer_host_device;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [1:0]  rst;
   logic        re, we;
   logic [31:0] ra, wa, wd;

   logic        rd_hit [2];
   logic        wr_hit [2];
   logic [31:0] rd_data[2];
   logic        rd_ev  [2];
   logic [3:0]  rd_ec  [2];
   logic        wr_ev  [2];
   logic [3:0]  wr_ec  [2];
   logic        irq    [2];
   logic        halt   [2];
   logic [30:0] hcode  [2];

   mmio_timer_host_device #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut_a (
      .CLK(CLK), .RESET(rst[0]),
      .in_read_enable(re), .in_read_address(ra),
      .in_write_enable(we), .in_write_address(wa), .in_write_data(wd),
      .out_read_hit(rd_hit[0]), .out_write_hit(wr_hit[0]), .out_read_data(rd_data[0]),
      .out_read_exception_valid(rd_ev[0]), .out_read_exception_code(rd_ec[0]),
      .out_write_exception_valid(wr_ev[0]), .out_write_exception_code(wr_ec[0]),
      .out_timer_interrupt(irq[0]), .out_halt(halt[0]), .out_halt_code(hcode[0])
   );

   mmio_timer_host_device #(.BASE_ADDR(BASE), .TICK_DIV(3)) dut_b (
      .CLK(CLK), .RESET(rst[1]),
      .in_read_enable(re), .in_read_address(ra),
      .in_write_enable(we), .in_write_address(wa), .in_write_data(wd),
      .out_read_hit(rd_hit[1]), .out_write_hit(wr_hit[1]), .out_read_data(rd_data[1]),
      .out_read_exception_valid(rd_ev[1]), .out_read_exception_code(rd_ec[1]),
      .out_write_exception_valid(wr_ev[1]), .out_write_exception_code(wr_ec[1]),
      .out_timer_interrupt(irq[1]), .out_halt(halt[1]), .out_halt_code(hcode[1])
   );

   // Model: mtime = base + (unhalted cycles since last mtime write or reset) / TICK_DIV.
   typedef struct {
      logic [63:0] base;
      int unsigned elapsed;
      logic [63:0] cmp;
      logic [31:0] tohost;
      logic [31:0] fromhost;
      logic        halt;
      logic [30:0] code;
      logic        irq;
   } mstate_t;

   mstate_t m[2];
   int      n_checks = 0;
   int      n_pass   = 0;
   bit      checking = 0;

   function automatic int unsigned div_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [63:0] mtime_of(input mstate_t s, input int unsigned d);
      return s.base + 64'(s.elapsed / d);
   endfunction

   function automatic bit in_window(input logic [31:0] a);
      return a[31:12] == 20'h02000;
   endfunction

   function automatic logic [3:0] fault(input logic [31:0] a, input logic [3:0] mis,
                                        input logic [3:0] unm);
      if (a[1:0] != 2'b00) return mis;
      case (a[11:0])
         12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014: return 4'd0;
         default: return unm;
      endcase
   endfunction

   function automatic logic [3:0] exp_rcode(input logic en, input logic [31:0] a);
      return (en && in_window(a)) ? fault(a, 4'd4, 4'd5) : 4'd0;
   endfunction

   function automatic logic [3:0] exp_wcode(input logic en, input logic [31:0] a);
      return (en && in_window(a)) ? fault(a, 4'd6, 4'd7) : 4'd0;
   endfunction

   function automatic logic [31:0] exp_rdata(input mstate_t s, input int unsigned d,
                                             input logic en, input logic [31:0] a);
      logic [63:0] t;
      t = mtime_of(s, d);
      if (!en || !in_window(a) || exp_rcode(en, a) != 4'd0) return 32'd0;
      case (a[11:0])
         12'h000: return t[31:0];
         12'h004: return t[63:32];
         12'h008: return s.cmp[31:0];
         12'h00C: return s.cmp[63:32];
         12'h010: return s.tohost;
         12'h014: return s.fromhost;
         default: return 32'd0;
      endcase
   endfunction

   function automatic mstate_t reset_state();
      mstate_t r;
      r.base = 64'd0; r.elapsed = 0; r.cmp = '1; r.tohost = 32'd0; r.fromhost = 32'd0;
      r.halt = 1'b0; r.code = 31'd0; r.irq = 1'b0;
      return r;
   endfunction

   function automatic mstate_t step(input mstate_t s, input int unsigned d, input logic r,
                                    input logic en, input logic [31:0] a, input logic [31:0] data);
      mstate_t     n;
      logic [63:0] cur;
      if (r) return reset_state();
      n   = s;
      cur = mtime_of(s, d);
      if (!s.halt) n.elapsed = s.elapsed + 1;
      if (en && in_window(a) && exp_wcode(en, a) == 4'd0) begin
         case (a[11:0])
            12'h000: begin n.base = {cur[63:32], data}; n.elapsed = 0; end
            12'h004: begin n.base = {data, cur[31:0]};  n.elapsed = 0; end
            12'h008: n.cmp[31:0]  = data;
            12'h00C: n.cmp[63:32] = data;
            12'h010: begin
               n.tohost = data;
               if (data[0] && !s.halt) begin n.halt = 1'b1; n.code = data[31:1]; end
            end
            12'h014: n.fromhost = data;
            default: ;
         endcase
      end
      n.irq = (mtime_of(n, d) >= n.cmp);
      return n;
   endfunction

   task automatic check(input string name, input int inst, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
   endtask

   // Model advances on the same edge as the DUTs.
   always @(posedge CLK) begin
      for (int i = 0; i < 2; i++)
         m[i] <= step(m[i], div_of(i), rst[i], we, wa, wd);
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge CLK) begin
      if (checking) begin
         for (int i = 0; i < 2; i++) begin
            check("rd_hit",   i, 64'(rd_hit[i]),  64'(in_window(ra)));
            check("wr_hit",   i, 64'(wr_hit[i]),  64'(in_window(wa)));
            check("rd_data",  i, 64'(rd_data[i]), 64'(exp_rdata(m[i], div_of(i), re, ra)));
            check("rd_code",  i, 64'(rd_ec[i]),   64'(exp_rcode(re, ra)));
            check("rd_valid", i, 64'(rd_ev[i]),   64'(exp_rcode(re, ra) != 4'd0));
            check("wr_code",  i, 64'(wr_ec[i]),   64'(exp_wcode(we, wa)));
            check("wr_valid", i, 64'(wr_ev[i]),   64'(exp_wcode(we, wa) != 4'd0));
            check("irq",      i, 64'(irq[i]),     64'(m[i].irq));
            check("halt",     i, 64'(halt[i]),    64'(m[i].halt));
            check("halt_code",i, 64'(hcode[i]),   64'(m[i].code));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] data);
      we = 1'b1; wa = a; wd = data;
      tick(1);
      we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a);
      re = 1'b1; ra = a;
      #1;
   endtask

   initial begin
      bit seen;
      rst = 2'b11; re = 1'b0; we = 1'b0; ra = 32'd0; wa = 32'd0; wd = 32'd0;
      tick(1);
      checking = 1;
      tick(2);

      // Idle count after reset (TICK_DIV = 1)
      rst[0] = 1'b0;
      re = 1'b1; ra = BASE;
      tick(10);
      rd(BASE);
      check("t1_mtime_lo", 0, 64'(rd_data[0]), 64'd10);
      check("t1_irq", 0, 64'(irq[0]), 64'd0);
      rd(BASE + 32'h8);
      check("t1_cmp_lo", 0, 64'(rd_data[0]), 64'hFFFF_FFFF);

      // Timer compare
      wr(BASE, 32'd0);
      wr(BASE + 32'hC, 32'd0);
      wr(BASE + 32'h8, 32'd20);
      ra = BASE;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         if (irq[0]) seen = 1;
         else tick(1);
      end
      check("t2_irq_rise", 0, 64'(seen), 64'd1);
      rd(BASE);
      check("t2_mtime_at_rise", 0, 64'(rd_data[0]), 64'd20);
      tick(3);
      check("t2_irq_hold", 0, 64'(irq[0]), 64'd1);
      wr(BASE + 32'h8, 32'd1000);
      check("t2_irq_drop", 0, 64'(irq[0]), 64'd0);

      // 64-bit wrap and write-vs-tick
      wr(BASE, 32'hFFFF_FFFF);
      wr(BASE + 32'h4, 32'hFFFF_FFFF);
      rd(BASE);
      check("t3_lo_ones", 0, 64'(rd_data[0]), 64'hFFFF_FFFF);
      tick(1);
      rd(BASE);
      check("t3_wrap_lo", 0, 64'(rd_data[0]), 64'd0);
      rd(BASE + 32'h4);
      check("t3_wrap_hi", 0, 64'(rd_data[0]), 64'd0);
      wr(BASE, 32'd5);
      rd(BASE);
      check("t3_write_wins", 0, 64'(rd_data[0]), 64'd5);

      // tohost halt, freeze, sticky code, fromhost
      wr(BASE + 32'h10, 32'h0000_0003);
      check("t4_halt", 0, 64'(halt[0]), 64'd1);
      check("t4_code", 0, 64'(hcode[0]), 64'd1);
      tick(3);
      rd(BASE);
      check("t4_frozen", 0, 64'(rd_data[0]), 64'd6);
      wr(BASE + 32'h10, 32'h0000_0005);
      check("t4_code_sticky", 0, 64'(hcode[0]), 64'd1);
      rd(BASE + 32'h10);
      check("t4_tohost", 0, 64'(rd_data[0]), 64'd5);
      wr(BASE + 32'h14, 32'hA5A5_0001);
      rd(BASE + 32'h14);
      check("t4_fromhost", 0, 64'(rd_data[0]), 64'hA5A5_0001);

      // Faults
      tick(1);
      rd(BASE + 32'h2);
      check("t5_rd_mis_code", 0, 64'(rd_ec[0]), 64'd4);
      check("t5_rd_mis_data", 0, 64'(rd_data[0]), 64'd0);
      rd(BASE + 32'h20);
      check("t5_rd_unm_code", 0, 64'(rd_ec[0]), 64'd5);
      tick(1);
      we = 1'b1; wa = BASE + 32'h6; wd = 32'h1234_5678;
      #1;
      check("t5_wr_mis_code", 0, 64'(wr_ec[0]), 64'd6);
      tick(1);
      we = 1'b0;
      rd(BASE + 32'h4);
      check("t5_no_change", 0, 64'(rd_data[0]), 64'd0);
      we = 1'b1; wa = BASE + 32'hFF0; wd = 32'h1;
      #1;
      check("t5_wr_unm_code", 0, 64'(wr_ec[0]), 64'd7);
      tick(1);
      we = 1'b0;
      rd(32'h8000_0000);
      check("t5_out_hit", 0, 64'(rd_hit[0]), 64'd0);
      check("t5_out_exc", 0, 64'(rd_ev[0]), 64'd0);
      check("t5_out_data", 0, 64'(rd_data[0]), 64'd0);

      // TICK_DIV = 3 and reset over a concurrent tohost write
      rst[1] = 1'b0;
      tick(9);
      rd(BASE);
      check("t6_div3_mtime", 1, 64'(rd_data[1]), 64'd3);
      tick(1);
      rst = 2'b11;
      we = 1'b1; wa = BASE + 32'h10; wd = 32'h3;
      tick(1);
      we = 1'b0;
      check("t6_halt_a", 0, 64'(halt[0]), 64'd0);
      check("t6_halt_b", 1, 64'(halt[1]), 64'd0);
      rd(BASE);
      check("t6_mtime_b", 1, 64'(rd_data[1]), 64'd0);
      rd(BASE + 32'h8);
      check("t6_cmp_a", 0, 64'(rd_data[0]), 64'hFFFF_FFFF);
      tick(1);
      rd(BASE + 32'h10);
      check("t6_tohost_b", 1, 64'(rd_data[1]), 64'd0);
      rst = 2'b00;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
